// File: rtl/wordle_pkg.sv
// Shared encodings for the keypad front end of the Wordle design:
// scan/debounce state types, scan result type and the keypad key map.
package wordle_pkg;

    typedef enum logic [1:0] {
        SC_START,
        SC_DRIVE,
        SC_SETTLE,
        SC_SAMPLE
    } scan_state_t;

    typedef enum logic {
        DB_RELEASED,
        DB_PRESSED
    } db_state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } scan_result_t;

    // Nibble i holds the hex legend of the key at index i = col*4 + row.
    localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

    function automatic logic [3:0] key_hex(input logic [3:0] idx);
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release qualification of per-scan keypad results; emits a one-cycle
// key event, a held key_down level and the last accepted key code.
module keypad_debounce
    import wordle_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic         segclk,
    input  logic         clr,
    input  logic         scan_done,
    input  scan_result_t res_type,
    input  logic [3:0]   res_key,
    output logic [3:0]   key_code,
    output logic         key_valid,
    output logic         key_down
);

    localparam logic [3:0] TARGET = 4'(DEBOUNCE);

    db_state_t  state, state_n;
    logic [3:0] cand, cand_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] rcnt, rcnt_n;
    logic [3:0] code_n;
    logic       valid_n;
    logic       down_n;

    always_ff @(posedge segclk) begin
        if (clr) begin
            state     <= DB_RELEASED;
            cand      <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            rcnt      <= rcnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        rcnt_n  = rcnt;
        code_n  = key_code;
        valid_n = 1'b0;
        down_n  = key_down;
        if (scan_done) begin
            case (state)
                DB_RELEASED: begin
                    if (res_type == RES_SINGLE) begin
                        cand_n = res_key;
                        cnt_n  = (res_key == cand) ? sat_inc(cnt) : 4'd1;
                        if (cnt_n >= TARGET) begin
                            state_n = DB_PRESSED;
                            code_n  = res_key;
                            down_n  = 1'b1;
                            valid_n = 1'b1;
                            rcnt_n  = '0;
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                DB_PRESSED: begin
                    // Any key activity, even a different key, holds off release.
                    if (res_type == RES_NONE) begin
                        rcnt_n = sat_inc(rcnt);
                        if (rcnt_n >= TARGET) begin
                            state_n = DB_RELEASED;
                            down_n  = 1'b0;
                            cnt_n   = '0;
                            rcnt_n  = '0;
                        end
                    end else begin
                        rcnt_n = '0;
                    end
                end
                default: state_n = DB_RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner: strobes one active-low column at a time on the
// display scan clock, classifies each full scan and hands it to the debouncer.
module keypad_scan
    import wordle_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       segclk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    scan_state_t  state, state_n;
    logic [1:0]   idx, idx_n;
    logic [3:0]   col_n;
    logic [3:0]   row_m, row_s;
    logic [3:0]   acc_cnt, acc_cnt_n;
    logic [3:0]   acc_key, acc_key_n;

    logic [3:0]   hit;
    logic [2:0]   col_hits;
    logic [1:0]   first_r;
    logic [4:0]   total_w;
    logic [3:0]   total;
    logic [3:0]   first_key;
    logic         scan_done;
    scan_result_t res_type;

    always_ff @(posedge segclk) begin
        if (clr) begin
            state   <= SC_START;
            idx     <= '0;
            col     <= '1;
            row_m   <= '1;
            row_s   <= '1;
            acc_cnt <= '0;
            acc_key <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            col     <= col_n;
            row_m   <= row;
            row_s   <= row_m;
            acc_cnt <= acc_cnt_n;
            acc_key <= acc_key_n;
        end
    end

    assign hit      = ~row_s;
    assign col_hits = {2'b00, hit[0]} + {2'b00, hit[1]} + {2'b00, hit[2]} + {2'b00, hit[3]};

    always_comb begin
        if (hit[0])      first_r = 2'd0;
        else if (hit[1]) first_r = 2'd1;
        else if (hit[2]) first_r = 2'd2;
        else             first_r = 2'd3;
    end

    // Running total including the column being sampled right now, so the
    // scan result is ready during SAMPLE of column 3 without an extra cycle.
    assign total_w   = {1'b0, acc_cnt} + {2'b00, col_hits};
    assign total     = (total_w > 5'd15) ? 4'hF : total_w[3:0];
    assign first_key = (acc_cnt != '0) ? acc_key : key_hex({idx, first_r});
    assign scan_done = (state == SC_SAMPLE) && (idx == 2'd3);

    always_comb begin
        if (total == '0)        res_type = RES_NONE;
        else if (total == 4'd1) res_type = RES_SINGLE;
        else                    res_type = RES_MULTI;
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        col_n     = col;
        acc_cnt_n = acc_cnt;
        acc_key_n = acc_key;
        case (state)
            SC_START: begin
                state_n   = SC_DRIVE;
                idx_n     = '0;
                col_n     = 4'b1110;
                acc_cnt_n = '0;
                acc_key_n = '0;
            end
            SC_DRIVE:  state_n = SC_SETTLE;
            SC_SETTLE: state_n = SC_SAMPLE;
            SC_SAMPLE: begin
                state_n = SC_DRIVE;
                idx_n   = idx + 2'd1;
                col_n   = {col[2:0], col[3]};
                if (idx == 2'd3) begin
                    acc_cnt_n = '0;
                    acc_key_n = '0;
                end else begin
                    acc_cnt_n = total;
                    acc_key_n = first_key;
                end
            end
            default: state_n = SC_START;
        endcase
    end

    keypad_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .segclk   (segclk),
        .clr      (clr),
        .scan_done(scan_done),
        .res_type (res_type),
        .res_key  (first_key),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

endmodule
